// File: rtl/types_pkg.sv
// Shared types for the load/store queue and its data_memory interface.
package types_pkg;

  localparam int ROB_TAG_W = 5;

  typedef enum logic {IDLE, LD_WAIT} lsq_state_e;

  typedef struct packed {
    logic                 store;
    logic [2:0]           func3;
    logic [1:0]           sw_sh_signal;
    logic [5:0]           pd;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          pc;
    logic [31:0]          addr;
    logic [31:0]          ps2_data;
  } lsq;

  typedef struct packed {
    logic [31:0]          data;
    logic [5:0]           pd;
    logic [ROB_TAG_W-1:0] rob_fu_mem;
  } mem_data;

endpackage

// File: rtl/load_store_queue.sv
// In-order load/store queue feeding data_memory: stores issue once committed,
// loads issue as soon as their address is known, one load outstanding at a time.
module load_store_queue
  import types_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_valid,
  input  lsq                           disp_entry,
  output logic                         lsq_full,
  input  logic                         agu_valid,
  input  logic [ROB_TAG_W-1:0]         agu_rob_tag,
  input  logic [31:0]                  agu_addr,
  input  logic [31:0]                  agu_data,
  input  logic                         commit_valid,
  input  logic [ROB_TAG_W-1:0]         commit_tag,
  input  logic                         flush,
  output logic                         store_wb,
  output lsq                           lsq_in,
  output logic                         load_mem,
  output lsq                           lsq_load,
  input  logic                         mem_valid,
  input  mem_data                      mem_out,
  output logic [$clog2(DEPTH+1)-1:0]   lsq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  lsq                   entries [DEPTH];
  logic [DEPTH-1:0]     valid, addr_valid, committed;
  logic [DEPTH-1:0]     valid_n, addr_valid_n, committed_n, kept;
  logic [PW-1:0]        head, tail, head_n, tail_n, base, idx;
  logic [CW-1:0]        count, count_n, keep, avail;
  lsq_state_e           state, state_n;
  logic                 drop_resp, drop_resp_n, run;
  logic [ROB_TAG_W-1:0] drop_tag, drop_tag_n;
  logic                 last_ld_live;
  logic [ROB_TAG_W-1:0] last_ld_tag;
  lsq                   head_entry;
  logic                 store_issue, load_issue, resp_discard, resp_pop, alloc, pop;

  assign head_entry   = entries[head];
  assign lsq_full     = (count == CW'(DEPTH));
  assign lsq_count    = count;
  assign resp_discard = mem_valid && drop_resp && (mem_out.rob_fu_mem == drop_tag);
  assign resp_pop     = (state == LD_WAIT) && mem_valid && !resp_discard &&
                        (mem_out.rob_fu_mem == head_entry.rob_tag);
  assign alloc        = disp_valid && !lsq_full && !flush;
  assign pop          = store_issue || resp_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load_issue && !flush) state_n = LD_WAIT;
      LD_WAIT: if (flush || resp_pop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    store_issue = 1'b0;
    load_issue  = 1'b0;
    if (state == IDLE && valid[head] && addr_valid[head]) begin
      store_issue = head_entry.store && committed[head];
      load_issue  = !head_entry.store;
    end
    store_wb = store_issue;
    load_mem = load_issue;
    lsq_in   = store_issue ? head_entry : '0;
    lsq_load = load_issue ? head_entry : '0;
  end

  // Flush keeps only the committed stores that follow whatever the head has
  // already handed to data_memory (an issuing store or an in-flight load).
  always_comb begin
    valid_n      = valid;
    addr_valid_n = addr_valid;
    committed_n  = committed;
    head_n       = head;
    tail_n       = tail;
    count_n      = count;
    drop_resp_n  = drop_resp && !resp_discard;
    drop_tag_n   = drop_tag;
    base         = head;
    avail        = count;
    keep         = '0;
    kept         = '0;
    run          = 1'b1;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (agu_valid && valid[i] && entries[i].rob_tag == agu_rob_tag)
        addr_valid_n[i] = 1'b1;
      if (commit_valid && valid[i] && entries[i].store && entries[i].rob_tag == commit_tag)
        committed_n[i] = 1'b1;
    end
    if (flush) begin
      if (store_issue || load_issue || state == LD_WAIT) begin
        base  = head + 1'b1;
        avail = count - 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = base + PW'(i);
        if (run && i < int'(avail) && committed_n[idx]) begin
          kept[idx] = 1'b1;
          keep      = keep + 1'b1;
        end else begin
          run = 1'b0;
        end
      end
      valid_n      = kept;
      addr_valid_n = addr_valid_n & kept;
      committed_n  = committed_n & kept;
      head_n       = base;
      tail_n       = base + keep[PW-1:0];
      count_n      = keep;
      if (load_issue || (state == LD_WAIT && !resp_pop)) begin
        drop_resp_n = 1'b1;
        drop_tag_n  = head_entry.rob_tag;
      end
    end else begin
      if (pop) begin
        valid_n[head]      = 1'b0;
        addr_valid_n[head] = 1'b0;
        committed_n[head]  = 1'b0;
        head_n             = head + 1'b1;
      end
      if (alloc) begin
        valid_n[tail]      = 1'b1;
        addr_valid_n[tail] = 1'b0;
        committed_n[tail]  = 1'b0;
        tail_n             = tail + 1'b1;
      end
      count_n = count + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid        <= '0;
      addr_valid   <= '0;
      committed    <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      drop_resp    <= 1'b0;
      drop_tag     <= '0;
      last_ld_live <= 1'b0;
      last_ld_tag  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      valid      <= valid_n;
      addr_valid <= addr_valid_n;
      committed  <= committed_n;
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      drop_resp  <= drop_resp_n;
      drop_tag   <= drop_tag_n;
      for (int i = 0; i < DEPTH; i++) begin
        if (agu_valid && valid[i] && entries[i].rob_tag == agu_rob_tag) begin
          entries[i].addr     <= agu_addr;
          entries[i].ps2_data <= agu_data;
        end
      end
      if (alloc) entries[tail] <= disp_entry;
      if (store_issue) begin
        last_ld_live <= 1'b0;
      end else if (load_issue) begin
        last_ld_live <= 1'b1;
        last_ld_tag  <= head_entry.rob_tag;
      end
    end
  end

  // data_memory suppresses a repeated load tag, so such a load would never complete.
  a_repeat_load_tag: assert property (@(posedge clk) disable iff (reset)
    !(load_issue && last_ld_live && head_entry.rob_tag == last_ld_tag));

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed vector table, corner-case sequences and
// a randomized run checked against a queue-based reference model.
module tb_load_store_queue;
  import types_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid, agu_valid, commit_valid, flush, mem_valid;
  lsq          disp_entry, lsq_in, lsq_load;
  logic [4:0]  agu_rob_tag, commit_tag;
  logic [31:0] agu_addr, agu_data;
  mem_data     mem_out;
  logic        lsq_full, store_wb, load_mem;
  logic [3:0]  lsq_count;

  always #5 clk = ~clk;

  load_store_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_entry(disp_entry),
    .lsq_full(lsq_full), .agu_valid(agu_valid), .agu_rob_tag(agu_rob_tag),
    .agu_addr(agu_addr), .agu_data(agu_data), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .flush(flush), .store_wb(store_wb), .lsq_in(lsq_in),
    .load_mem(load_mem), .lsq_load(lsq_load), .mem_valid(mem_valid),
    .mem_out(mem_out), .lsq_count(lsq_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] seen_st[$];
  always @(negedge clk) if (store_wb === 1'b1) seen_st.push_back(lsq_in.rob_tag);

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic lsq mk_entry(input bit st, input logic [4:0] tag, input logic [31:0] pc);
    lsq e;
    e = '0;
    e.store        = st;
    e.func3        = 3'b010;
    e.sw_sh_signal = st ? 2'b10 : 2'b00;
    e.pd           = {1'b0, tag};
    e.rob_tag      = tag;
    e.pc           = pc;
    return e;
  endfunction

  task automatic idle_inputs();
    disp_valid = 0; disp_entry = '0; agu_valid = 0; agu_rob_tag = '0;
    agu_addr = '0; agu_data = '0; commit_valid = 0; commit_tag = '0;
    flush = 0; mem_valid = 0; mem_out = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic apply_stimulus(input int dv, input int st, input int dtag, input int av,
                                input int atag, input logic [31:0] addr, input logic [31:0] data,
                                input int cv, input int ctag, input int mv, input int mtag);
    disp_valid   = (dv != 0);
    disp_entry   = mk_entry(st != 0, 5'(dtag), 32'h1000 + 32'(dtag) * 4);
    agu_valid    = (av != 0);
    agu_rob_tag  = 5'(atag);
    agu_addr     = addr;
    agu_data     = data;
    commit_valid = (cv != 0);
    commit_tag   = 5'(ctag);
    mem_valid    = (mv != 0);
    mem_out      = '0;
    mem_out.rob_fu_mem = 5'(mtag);
    mem_out.data = 32'hDEADBEEF;
  endtask

  typedef struct {
    int dv, st, dtag, av, atag; logic [31:0] addr, data;
    int cv, ctag, mv, mtag;
    int e_swb, e_ld, e_cnt, e_tag; logic [31:0] e_addr, e_data;
  } vec_t;

  function automatic vec_t mkv(input int dv, st, dtag, av, atag, input logic [31:0] addr, data,
                               input int cv, ctag, mv, mtag, e_swb, e_ld, e_cnt, e_tag,
                               input logic [31:0] e_addr, e_data);
    vec_t v;
    v.dv = dv; v.st = st; v.dtag = dtag; v.av = av; v.atag = atag; v.addr = addr; v.data = data;
    v.cv = cv; v.ctag = ctag; v.mv = mv; v.mtag = mtag;
    v.e_swb = e_swb; v.e_ld = e_ld; v.e_cnt = e_cnt; v.e_tag = e_tag;
    v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  typedef struct { bit st; logic [4:0] tag; logic [31:0] addr, data; bit av, cm; } ment_t;

  vec_t vt[20];

  initial begin
    // ---- reset values
    reset = 1;
    idle_inputs();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_output("rst_store_wb", store_wb, 0);
    check_output("rst_load_mem", load_mem, 0);
    check_output("rst_count", lsq_count, 0);
    check_output("rst_full", lsq_full, 0);
    check_output("rst_lsq_in", lsq_in, 0);
    check_output("rst_lsq_load", lsq_load, 0);
    @(posedge clk); #1;
    reset = 0;

    // ---- reset while a load is outstanding
    apply_stimulus(1,0,8, 0,0,0,0, 0,0, 0,0);
    next_cycle(); apply_stimulus(0,0,0, 1,8,32'h200,0, 0,0, 0,0);
    next_cycle(); @(negedge clk);
    check_output("rldw_issue", load_mem, 1);
    next_cycle(); @(negedge clk);
    check_output("rldw_wait_ld", load_mem, 0);
    check_output("rldw_wait_cnt", lsq_count, 1);
    #1 reset = 1;
    #1;
    check_output("rldw_store_wb", store_wb, 0);
    check_output("rldw_load_mem", load_mem, 0);
    check_output("rldw_count", lsq_count, 0);
    check_output("rldw_full", lsq_full, 0);
    @(posedge clk); #1;
    reset = 0;
    apply_stimulus(0,0,0, 0,0,0,0, 0,0, 1,8);
    @(negedge clk);
    check_output("rldw_stale_cnt", lsq_count, 0);
    next_cycle(); @(negedge clk);
    check_output("rldw_after_cnt", lsq_count, 0);
    check_output("rldw_after_ld", load_mem, 0);

    // ---- vector table: store path, load path, store-before-load ordering
    vt[0]  = mkv(1,1,3, 0,0,0,0,                    0,0, 0,0, 0,0,0,0,0,0);
    vt[1]  = mkv(0,0,0, 1,3,32'h40,32'hDEADBEEF,    0,0, 0,0, 0,0,1,0,0,0);
    vt[2]  = mkv(0,0,0, 0,0,0,0,                    1,3, 0,0, 0,0,1,0,0,0);
    vt[3]  = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 1,0,1,3,32'h40,32'hDEADBEEF);
    vt[4]  = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 0,0,0,0,0,0);
    vt[5]  = mkv(1,0,5, 0,0,0,0,                    0,0, 0,0, 0,0,0,0,0,0);
    vt[6]  = mkv(0,0,0, 1,5,32'h40,0,               0,0, 0,0, 0,0,1,0,0,0);
    vt[7]  = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 0,1,1,5,32'h40,0);
    vt[8]  = mkv(0,0,0, 0,0,0,0,                    0,0, 1,5, 0,0,1,0,0,0);
    vt[9]  = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 0,0,0,0,0,0);
    vt[10] = mkv(1,1,1, 0,0,0,0,                    0,0, 0,0, 0,0,0,0,0,0);
    vt[11] = mkv(1,0,2, 0,0,0,0,                    0,0, 0,0, 0,0,1,0,0,0);
    vt[12] = mkv(0,0,0, 1,1,32'h80,32'h12345678,    0,0, 0,0, 0,0,2,0,0,0);
    vt[13] = mkv(0,0,0, 1,2,32'h84,0,               0,0, 0,0, 0,0,2,0,0,0);
    vt[14] = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 0,0,2,0,0,0);
    vt[15] = mkv(0,0,0, 0,0,0,0,                    1,1, 0,0, 0,0,2,0,0,0);
    vt[16] = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 1,0,2,1,32'h80,32'h12345678);
    vt[17] = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 0,1,1,2,32'h84,0);
    vt[18] = mkv(0,0,0, 0,0,0,0,                    0,0, 1,2, 0,0,1,0,0,0);
    vt[19] = mkv(0,0,0, 0,0,0,0,                    0,0, 0,0, 0,0,0,0,0,0);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      apply_stimulus(vt[i].dv, vt[i].st, vt[i].dtag, vt[i].av, vt[i].atag, vt[i].addr,
                     vt[i].data, vt[i].cv, vt[i].ctag, vt[i].mv, vt[i].mtag);
      @(negedge clk);
      check_output($sformatf("vec%0d_store_wb", i), store_wb, 64'(vt[i].e_swb));
      check_output($sformatf("vec%0d_load_mem", i), load_mem, 64'(vt[i].e_ld));
      check_output($sformatf("vec%0d_count", i), lsq_count, 64'(vt[i].e_cnt));
      check_output($sformatf("vec%0d_full", i), lsq_full, 0);
      if (vt[i].e_swb != 0) begin
        check_output($sformatf("vec%0d_st_tag", i), lsq_in.rob_tag, 64'(vt[i].e_tag));
        check_output($sformatf("vec%0d_st_addr", i), lsq_in.addr, vt[i].e_addr);
        check_output($sformatf("vec%0d_st_data", i), lsq_in.ps2_data, vt[i].e_data);
      end
      if (vt[i].e_ld != 0) begin
        check_output($sformatf("vec%0d_ld_tag", i), lsq_load.rob_tag, 64'(vt[i].e_tag));
        check_output($sformatf("vec%0d_ld_addr", i), lsq_load.addr, vt[i].e_addr);
      end
    end

    // ---- full, ignored dispatch, drain and wrap
    do_reset();
    seen_st.delete();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1,1,10+i, 0,0,0,0, 0,0, 0,0);
      next_cycle();
    end
    apply_stimulus(1,1,18, 0,0,0,0, 0,0, 0,0);
    @(negedge clk);
    check_output("full_flag", lsq_full, 1);
    check_output("full_count", lsq_count, 8);
    next_cycle(); @(negedge clk);
    check_output("full_ignored_count", lsq_count, 8);
    for (int i = 0; i < 8; i++) begin
      next_cycle(); apply_stimulus(0,0,0, 1,10+i,32'h100 + 32'(i)*4,32'(i), 0,0, 0,0);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle(); apply_stimulus(0,0,0, 0,0,0,0, 1,10+i, 0,0);
    end
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    check_output("drain_count", lsq_count, 0);
    check_output("drain_full", lsq_full, 0);
    check_output("drain_num_stores", seen_st.size(), 8);
    for (int i = 0; i < seen_st.size() && i < 8; i++)
      check_output($sformatf("drain_order%0d", i), seen_st[i], 64'(10+i));
    seen_st.delete();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); apply_stimulus(1,1,20+i, 0,0,0,0, 0,0, 0,0);
    end
    next_cycle(); @(negedge clk);
    check_output("refill_count", lsq_count, 3);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); apply_stimulus(0,0,0, 1,20+i,32'h180,0, 0,0, 0,0);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); apply_stimulus(0,0,0, 0,0,0,0, 1,20+i, 0,0);
    end
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    check_output("wrap_count", lsq_count, 0);
    check_output("wrap_num_stores", seen_st.size(), 3);
    for (int i = 0; i < seen_st.size() && i < 3; i++)
      check_output($sformatf("wrap_order%0d", i), seen_st[i], 64'(20+i));

    // ---- flush with a load outstanding and a committed store behind it
    do_reset();
    apply_stimulus(1,0,5, 0,0,0,0, 0,0, 0,0);
    next_cycle(); apply_stimulus(1,1,4, 0,0,0,0, 0,0, 0,0);
    next_cycle(); apply_stimulus(1,0,6, 0,0,0,0, 0,0, 0,0);
    next_cycle(); apply_stimulus(0,0,0, 1,5,32'h300,0, 0,0, 0,0);
    next_cycle(); apply_stimulus(0,0,0, 1,4,32'h304,32'hCAFEF00D, 0,0, 0,0);
    @(negedge clk);
    check_output("flush_ld_issue", load_mem, 1);
    check_output("flush_ld_tag", lsq_load.rob_tag, 5);
    next_cycle(); apply_stimulus(0,0,0, 0,0,0,0, 1,4, 0,0);
    @(negedge clk);
    check_output("flush_wait_ld", load_mem, 0);
    check_output("flush_pre_count", lsq_count, 3);
    next_cycle(); flush = 1;
    @(negedge clk);
    check_output("flush_cycle_count", lsq_count, 3);
    next_cycle(); apply_stimulus(0,0,0, 0,0,0,0, 0,0, 1,5);
    @(negedge clk);
    check_output("flush_post_count", lsq_count, 1);
    check_output("flush_store_wb", store_wb, 1);
    check_output("flush_store_tag", lsq_in.rob_tag, 4);
    check_output("flush_store_addr", lsq_in.addr, 32'h304);
    check_output("flush_store_data", lsq_in.ps2_data, 32'hCAFEF00D);
    check_output("flush_no_load", load_mem, 0);
    next_cycle(); @(negedge clk);
    check_output("flush_end_count", lsq_count, 0);
    check_output("flush_end_load", load_mem, 0);
    check_output("flush_end_store", store_wb, 0);

    // ---- randomized run against the reference model
    begin
      ment_t mq[$];
      ment_t ne;
      bit m_wait, m_drop, m_ll_live, e_swb, e_ld, discard, rpop, fl, dv, st;
      logic [4:0] m_droptag, m_ll_tag, tag_ctr, cur_tag, mtag;
      int n, k, r;
      m_wait = 0; m_drop = 0; m_ll_live = 0; tag_ctr = 0; m_droptag = 0; m_ll_tag = 0;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
        if (cyc != 0) next_cycle();
        n  = mq.size();
        fl = ($urandom_range(39, 0) == 0);
        dv = ($urandom_range(99, 0) < 55);
        st = $urandom_range(1, 0);
        if ((m_ll_live && tag_ctr == m_ll_tag) || (m_drop && tag_ctr == m_droptag)) st = 1;
        cur_tag    = tag_ctr;
        disp_valid = dv;
        disp_entry = mk_entry(st, cur_tag, $urandom());
        if (dv && n < DEPTH && !fl) tag_ctr = tag_ctr + 1;
        flush = fl;
        if (n > 0 && $urandom_range(1, 0) == 1) begin
          k = $urandom_range(n - 1, 0);
          agu_valid = 1; agu_rob_tag = mq[k].tag;
          agu_addr = $urandom() & 32'hFFFF_FFFC; agu_data = $urandom();
        end
        k = 0;
        while (k < n && mq[k].st && mq[k].cm) k++;
        if (k < n && mq[k].av && $urandom_range(3, 0) != 0) begin
          if (mq[k].st || $urandom_range(3, 0) == 0) begin
            commit_valid = 1; commit_tag = mq[k].tag;
          end
        end
        if (m_drop && $urandom_range(1, 0) == 1) begin
          mem_valid = 1; mem_out.rob_fu_mem = m_droptag;
        end else if (m_wait) begin
          r = $urandom_range(3, 0);
          if (r < 2) begin mem_valid = 1; mem_out.rob_fu_mem = mq[0].tag; end
          else if (r == 2) begin mem_valid = 1; mem_out.rob_fu_mem = mq[0].tag ^ 5'h10; end
        end
        mem_out.data = $urandom();
        @(negedge clk);
        e_swb = !m_wait && n > 0 && mq[0].st && mq[0].av && mq[0].cm;
        e_ld  = !m_wait && n > 0 && !mq[0].st && mq[0].av;
        check_output("rnd_store_wb", store_wb, 64'(e_swb));
        check_output("rnd_load_mem", load_mem, 64'(e_ld));
        check_output("rnd_count", lsq_count, 64'(n));
        check_output("rnd_full", lsq_full, 64'(n == DEPTH));
        if (e_swb) begin
          check_output("rnd_st_tag", lsq_in.rob_tag, mq[0].tag);
          check_output("rnd_st_addr", lsq_in.addr, mq[0].addr);
          check_output("rnd_st_data", lsq_in.ps2_data, mq[0].data);
        end
        if (e_ld) begin
          check_output("rnd_ld_tag", lsq_load.rob_tag, mq[0].tag);
          check_output("rnd_ld_addr", lsq_load.addr, mq[0].addr);
        end
        mtag    = mem_out.rob_fu_mem;
        discard = mem_valid && m_drop && mtag == m_droptag;
        if (discard) m_drop = 0;
        rpop = m_wait && mem_valid && !discard && mtag == mq[0].tag;
        foreach (mq[j]) begin
          if (agu_valid && mq[j].tag == agu_rob_tag) begin
            mq[j].addr = agu_addr; mq[j].data = agu_data; mq[j].av = 1;
          end
          if (commit_valid && mq[j].st && mq[j].tag == commit_tag) mq[j].cm = 1;
        end
        if (e_swb) m_ll_live = 0;
        if (e_ld) begin m_ll_live = 1; m_ll_tag = mq[0].tag; end
        if (fl) begin
          if (e_ld || (m_wait && !rpop)) begin m_drop = 1; m_droptag = mq[0].tag; end
          if (e_swb || e_ld || m_wait) void'(mq.pop_front());
          k = 0;
          while (k < mq.size() && mq[k].cm) k++;
          while (mq.size() > k) void'(mq.pop_back());
          m_wait = 0;
        end else begin
          if (e_swb || rpop) void'(mq.pop_front());
          if (rpop) m_wait = 0;
          if (e_ld) m_wait = 1;
          if (dv && n < DEPTH) begin
            ne.st = st; ne.tag = cur_tag; ne.addr = '0; ne.data = '0; ne.av = 0; ne.cm = 0;
            mq.push_back(ne);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
